// File: rtl/serpent_decrypt_ctrl.sv
// Sequencer for one Serpent block decryption: subkey fetch, key mixing and one inverse round per cycle.
// Optional define SERPENT_CTRL_KEYCHK_EN adds o_err and aborts the block when i_key_valid drops mid-block.
module serpent_decrypt_ctrl #(
  parameter int ROUNDS     = 32,
  parameter int KEY_ADDR_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_key_valid,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [127:0]          i_data,
  output logic                  o_key_rd,
  output logic [KEY_ADDR_W-1:0] o_key_addr,
  input  logic [127:0]          i_key,
  output logic [127:0]          o_stage_data,
  output logic [KEY_ADDR_W-1:0] o_stage_round,
  input  logic [127:0]          i_stage_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [127:0]          o_data,
  output logic                  o_busy
`ifdef SERPENT_CTRL_KEYCHK_EN
  ,
  output logic                  o_err
`endif
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
  // o_valid/o_data hold steady until taken, o_ready is a combinational decode of IDLE.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MIX   = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [KEY_ADDR_W-1:0] LAST_KEY  = KEY_ADDR_W'(ROUNDS);
  localparam logic [KEY_ADDR_W-1:0] FIRST_RND = KEY_ADDR_W'(ROUNDS - 1);
  localparam logic [KEY_ADDR_W-1:0] ONE       = KEY_ADDR_W'(1);

  state_t                  state_q, state_d;
  logic [127:0]            work_q;
  logic [127:0]            data_q;
  logic [KEY_ADDR_W-1:0]   rnd_q;
  logic [KEY_ADDR_W-1:0]   addr_q;
  logic                    key_rd;
  logic [KEY_ADDR_W-1:0]   key_addr;
  logic                    accept;
  logic                    abort;
  logic                    last_rnd;
  logic [127:0]            round_out;

  assign o_ready   = (state_q == S_IDLE) && i_key_valid;
  assign accept    = i_valid && o_ready;
  assign last_rnd  = (rnd_q == '0);
  assign round_out = i_stage_data ^ i_key;

`ifdef SERPENT_CTRL_KEYCHK_EN
  logic err_q;
  assign abort = ((state_q == S_FETCH) || (state_q == S_MIX) || (state_q == S_ROUND))
                 && !i_key_valid;
  assign o_err = err_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) err_q <= 1'b0;
    else         err_q <= abort;
  end
`else
  assign abort = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_FETCH;
      S_FETCH: state_d = S_MIX;
      S_MIX:   state_d = S_ROUND;
      S_ROUND: if (last_rnd) state_d = S_DONE;
      S_DONE:  if (i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Output logic: each read is issued one cycle before its subkey is consumed.
  always_comb begin
    key_rd   = 1'b0;
    key_addr = addr_q;
    case (state_q)
      S_FETCH: begin
        key_rd   = 1'b1;
        key_addr = LAST_KEY;
      end
      S_MIX: begin
        key_rd   = 1'b1;
        key_addr = FIRST_RND;
      end
      S_ROUND: begin
        if (!last_rnd) begin
          key_rd   = 1'b1;
          key_addr = rnd_q - ONE;
        end
      end
      default: begin
        key_rd   = 1'b0;
        key_addr = addr_q;
      end
    endcase
  end

  assign o_key_rd      = key_rd;
  assign o_key_addr    = key_addr;
  assign o_stage_data  = work_q;
  assign o_stage_round = rnd_q;
  assign o_data        = data_q;
  assign o_valid       = (state_q == S_DONE);
  assign o_busy        = (state_q != S_IDLE);

  // Datapath: working block, round counter, held address and result register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      work_q <= '0;
      data_q <= '0;
      rnd_q  <= '0;
      addr_q <= '0;
    end else begin
      addr_q <= key_addr;
      case (state_q)
        S_IDLE: begin
          if (accept) work_q <= i_data;
        end
        S_MIX: begin
          work_q <= work_q ^ i_key;
          rnd_q  <= FIRST_RND;
        end
        S_ROUND: begin
          work_q <= round_out;
          if (!last_rnd) rnd_q  <= rnd_q - ONE;
          else           data_q <= round_out;
        end
        default: begin
          work_q <= work_q;
        end
      endcase
    end
  end

endmodule
